// File: rtl/exe_unit_w2.sv
// Two-state execution unit.
// Single-cycle ALU ops complete on the accept edge; multiply runs as an
// M-iteration shift-add sequence before it completes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready; single-cycle ops complete here, multiply may start
// S_MUL  | shift-add multiply in progress; new requests are ignored
module exe_unit_w2 #(
   parameter int M = 8
) (
   input  logic         i_clk,
   input  logic         i_rsn,
   input  logic         i_valid,
   input  logic [2:0]   i_oper,
   input  logic [M-1:0] i_argA,
   input  logic [M-1:0] i_argB,
   output logic         o_ready,
   output logic         o_valid,
   output logic [M-1:0] o_result,
   output logic [3:0]   o_status
);

   localparam int LOGM = $clog2(M);
   localparam logic [LOGM-1:0] CNT_LAST = LOGM'(M - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [2*M-1:0]  a_q, a_d;
   logic [M-1:0]    b_q, b_d;
   logic [2*M-1:0]  acc_q, acc_d;
   logic [LOGM-1:0] cnt_q, cnt_d;
   logic [M-1:0]    result_q, result_d;
   logic [3:0]      status_q, status_d;
   logic            valid_q, valid_d;

   logic [M:0]      add_w;
   logic [M:0]      sub_w;
   logic [M:0]      shl_w;
   logic [M-1:0]    alu_res;
   logic            alu_c;
   logic            alu_v;
   logic [3:0]      alu_status;
   logic [2*M-1:0]  mul_sum_w;
   logic [3:0]      mul_status;

   // Single-cycle ALU: result and flags straight from the request inputs.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      add_w   = {1'b0, i_argA} + {1'b0, i_argB};
      // bit M of the extended difference is the borrow (A < B)
      sub_w   = {1'b0, i_argA} - {1'b0, i_argB};
      // bit M holds the last bit shifted out, A[M-sh]; it is 0 when sh == 0
      shl_w   = {1'b0, i_argA} << i_argB[LOGM-1:0];
      case (i_oper)
         3'b000: begin
            alu_res = add_w[M-1:0];
            alu_c   = add_w[M];
            alu_v   = (i_argA[M-1] == i_argB[M-1]) && (add_w[M-1] != i_argA[M-1]);
         end
         3'b001: begin
            alu_res = sub_w[M-1:0];
            alu_c   = sub_w[M];
            alu_v   = (i_argA[M-1] != i_argB[M-1]) && (sub_w[M-1] != i_argA[M-1]);
         end
         3'b010: alu_res = i_argA & i_argB;
         3'b011: alu_res = i_argA | i_argB;
         3'b100: alu_res = i_argA ^ i_argB;
         3'b101: begin
            alu_res = shl_w[M-1:0];
            alu_c   = shl_w[M];
         end
         3'b110: alu_res = {{(M-1){1'b0}}, (i_argA < i_argB)};
         default: alu_res = '0;
      endcase
      alu_status = {alu_res[M-1], alu_v, alu_c, ~|alu_res};
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      mul_sum_w  = acc_q + (b_q[0] ? a_q : '0);
      mul_status = {mul_sum_w[M-1], 1'b0, |mul_sum_w[2*M-1:M], ~|mul_sum_w[M-1:0]};
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      status_d = status_q;
      valid_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               if (i_oper == 3'b111) begin
                  a_d     = {{M{1'b0}}, i_argA};
                  b_d     = i_argB;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_MUL;
               end else begin
                  result_d = alu_res;
                  status_d = alu_status;
                  valid_d  = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d = mul_sum_w;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               result_d = mul_sum_w[M-1:0];
               status_d = mul_status;
               valid_d  = 1'b1;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         status_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         status_q <= status_d;
         valid_q  <= valid_d;
      end
   end

   assign o_ready  = (state_q == S_IDLE);
   assign o_valid  = valid_q;
   assign o_result = result_q;
   assign o_status = status_q;

endmodule
